// File: rtl/uart_rx_pkg.sv
// Shared definitions for the multi-mode UART receiver: parity encodings,
// deframer states, FIFO entry width and configuration decode helpers.
package uart_rx_pkg;

  localparam logic [2:0] PAR_NONE  = 3'b000;
  localparam logic [2:0] PAR_EVEN  = 3'b001;
  localparam logic [2:0] PAR_ODD   = 3'b010;
  localparam logic [2:0] PAR_MARK  = 3'b011;
  localparam logic [2:0] PAR_SPACE = 3'b100;

  localparam int ENTRY_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  // Out-of-range widths fall back to the common 8-bit frame.
  function automatic logic [3:0] decode_bits(input logic [3:0] cfg);
    if (cfg >= 4'd5 && cfg <= 4'd9) return cfg;
    else                            return 4'd8;
  endfunction

  function automatic logic [2:0] decode_parity(input logic [2:0] cfg);
    if (cfg > PAR_SPACE) return PAR_NONE;
    else                 return cfg;
  endfunction

  // Unused upper data bits are zero, so reducing over all nine bits is safe.
  function automatic logic parity_err(input logic [2:0] mode,
                                      input logic [8:0] data,
                                      input logic       p);
    case (mode)
      PAR_EVEN:  return ^{data, p};
      PAR_ODD:   return ~^{data, p};
      PAR_MARK:  return ~p;
      PAR_SPACE: return p;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_multi_mode_if.sv
// Read-side bus between the receiver and the APB register block.
interface uart_rx_multi_mode_if;

  logic       rd_en;
  logic       clr_err;
  logic [8:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_valid;
  logic       overflow;
  logic       break_det;
  logic       rx_idle;

  modport master (
    output rd_en, clr_err,
    input  rx_data, rx_perr, rx_ferr, rx_valid, overflow, break_det, rx_idle
  );

  modport slave (
    input  rd_en, clr_err,
    output rx_data, rx_perr, rx_ferr, rx_valid, overflow, break_det, rx_idle
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; the head word is presented combinationally
// and a push into a full FIFO is accepted only when a pop frees the slot.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_multi_mode.sv
// Multi-mode UART receiver: synchroniser, 3-tap majority filter, deframer FSM
// for 5..9 data bits with parity and 1/2 stop bits, break detection, RX FIFO.
module uart_rx_multi_mode
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_en,
  input  logic                 rx,
  input  logic [3:0]           cfg_data_bits,
  input  logic [2:0]           cfg_parity,
  input  logic                 cfg_stop2,
  uart_rx_multi_mode_if.slave  bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  logic       sync1, sync2;
  logic [2:0] samp;
  logic       filt;

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_idx, bit_n;
  logic [8:0]    data_q, data_n;
  logic [3:0]    nbits_q, nbits_n;
  logic [2:0]    par_q, par_n;
  logic          stop2_q, stop2_n;
  logic          perr_q, perr_n;
  logic          pbit_q, pbit_n;
  logic          second_q, second_n;
  logic          push_req;
  logic          ferr_bit;
  logic          brk_set;

  logic [ENTRY_W-1:0]         head;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       pop_eff;
  logic                       overflow_set;
  logic                       overflow_q, break_q, idle_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      samp  <= 3'b111;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      if (baud_en) samp <= {samp[1:0], sync2};
    end
  end

  assign filt = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      nbits_q  <= 4'd8;
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      perr_q   <= 1'b0;
      pbit_q   <= 1'b0;
      second_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      data_q   <= data_n;
      nbits_q  <= nbits_n;
      par_q    <= par_n;
      stop2_q  <= stop2_n;
      perr_q   <= perr_n;
      pbit_q   <= pbit_n;
      second_q <= second_n;
    end
  end

  // Configuration is captured only once the start bit is validated, so
  // register writes during a frame cannot corrupt it.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    data_n   = data_q;
    nbits_n  = nbits_q;
    par_n    = par_q;
    stop2_n  = stop2_q;
    perr_n   = perr_q;
    pbit_n   = pbit_q;
    second_n = second_q;
    push_req = 1'b0;
    ferr_bit = 1'b0;
    brk_set  = 1'b0;
    if (baud_en) begin
      case (state)
        IDLE: begin
          if (!filt) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (filt) begin
            state_n = IDLE;
          end else if (cnt == HALF_LAST) begin
            state_n  = DATA;
            cnt_n    = '0;
            bit_n    = '0;
            data_n   = '0;
            nbits_n  = decode_bits(cfg_data_bits);
            par_n    = decode_parity(cfg_parity);
            stop2_n  = cfg_stop2;
            perr_n   = 1'b0;
            pbit_n   = 1'b0;
            second_n = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt_n  = '0;
            data_n = data_q | (9'(filt) << bit_idx);
            bit_n  = bit_idx + 1'b1;
            if (bit_idx == nbits_q - 4'd1)
              state_n = (par_q == PAR_NONE) ? STOP : PARITY;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt_n    = '0;
            pbit_n   = filt;
            perr_n   = parity_err(par_q, data_q, filt);
            second_n = 1'b0;
            state_n  = STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt_n = '0;
            // A low first stop bit after an all-zero frame is a break, not data.
            if (!second_q && !filt && data_q == '0 && (par_q == PAR_NONE || !pbit_q)) begin
              brk_set = 1'b1;
              state_n = BRK_WAIT;
            end else if (!second_q && stop2_q && filt) begin
              second_n = 1'b1;
            end else begin
              ferr_bit = ~filt;
              push_req = 1'b1;
              state_n  = IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        BRK_WAIT: begin
          if (filt) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (bus.rd_en),
    .wdata ({ferr_bit, perr_q, data_q}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop_eff      = bus.rd_en && !fifo_empty;
  assign overflow_set = push_req && fifo_full && !pop_eff;

  // Sticky flags: a set in the same cycle as CLR_ERR takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      break_q    <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      overflow_q <= overflow_set | (overflow_q & ~bus.clr_err);
      break_q    <= brk_set | (break_q & ~bus.clr_err);
      idle_q     <= (state == IDLE);
    end
  end

  assign bus.rx_valid  = (fifo_count != '0);
  assign bus.rx_data   = fifo_empty ? 9'd0 : head[8:0];
  assign bus.rx_perr   = fifo_empty ? 1'b0 : head[9];
  assign bus.rx_ferr   = fifo_empty ? 1'b0 : head[10];
  assign bus.overflow  = overflow_q;
  assign bus.break_det = break_q;
  assign bus.rx_idle   = idle_q;

endmodule

// File: tb/tb_uart_rx_multi_mode.sv
// Self-checking bench for uart_rx_multi_mode: directed frames, a queue model
// of received words and sticky flags, and a per-cycle compare process.
module tb_uart_rx_multi_mode;
  import uart_rx_pkg::*;

  localparam int OS       = 16;
  localparam int DEPTH    = 4;
  localparam int BAUD_DIV = 4;
  localparam int BIT_CLKS = OS * BAUD_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_en = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [2:0] cfg_parity = PAR_NONE;
  logic       cfg_stop2 = 1'b0;

  uart_rx_multi_mode_if bus();

  uart_rx_multi_mode #(
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_en       (baud_en),
    .rx            (rx),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) baud_en = ((cyc % BAUD_DIV) == BAUD_DIV - 1);

  logic [10:0] q[$];
  bit          expOverflow = 1'b0;
  bit          expBreak = 1'b0;
  bit          modelLive = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  int          frameStart = 0;
  int          latency = 0;
  int          riseCyc = 0;
  logic        prevValid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (modelLive) begin
      checkOutput("model_valid", bus.rx_valid, q.size() != 0);
      if (q.size() != 0) begin
        checkOutput("model_data", bus.rx_data, q[0][8:0]);
        checkOutput("model_perr", bus.rx_perr, q[0][9]);
        checkOutput("model_ferr", bus.rx_ferr, q[0][10]);
      end
      checkOutput("model_overflow", bus.overflow, expOverflow);
      checkOutput("model_break", bus.break_det, expBreak);
      checkOutput("model_idle", bus.rx_idle, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (bus.rx_valid && !prevValid) riseCyc = cyc;
    prevValid = bus.rx_valid;
  end

  task automatic driveBit(input logic v, input int ticks);
    rx = v;
    repeat (ticks * BAUD_DIV) @(negedge clk);
  endtask

  task automatic alignToBaud();
    @(negedge clk);
    while ((cyc % BAUD_DIV) != 0) @(negedge clk);
  endtask

  // badStop: 0 all stop bits good, 1 first stop low, 2 second stop low.
  task automatic applyStimulus(input logic [8:0] data, input int nbits, input logic [2:0] par,
                               input bit flip, input bit stop2, input int badStop,
                               input bit coincidentPop);
    logic [8:0]  d;
    logic        p;
    bit          isBreak;
    logic [10:0] entry;
    d = data & 9'((1 << nbits) - 1);
    cfg_data_bits = 4'(nbits);
    cfg_parity    = par;
    cfg_stop2     = stop2;
    case (par)
      PAR_EVEN:  p = ^d;
      PAR_ODD:   p = ~^d;
      PAR_MARK:  p = 1'b1;
      default:   p = 1'b0;
    endcase
    p = p ^ flip;
    if (coincidentPop) checkOutput("latency_known", latency > 1, 1'b1);
    modelLive = 1'b0;
    alignToBaud();
    frameStart = cyc;
    fork
      begin
        driveBit(1'b0, OS);
        for (int i = 0; i < nbits; i++) driveBit(d[i], OS);
        if (par != PAR_NONE) driveBit(p, OS);
        if (badStop == 1) begin driveBit(1'b0, 12); driveBit(1'b1, OS - 12); end
        else driveBit(1'b1, OS);
        if (stop2) begin
          if (badStop == 2) begin driveBit(1'b0, 12); driveBit(1'b1, OS - 12); end
          else driveBit(1'b1, OS);
        end
        driveBit(1'b1, 2 * OS);
      end
      begin
        if (coincidentPop && latency > 1) begin
          repeat (latency - 1) @(negedge clk);
          bus.rd_en = 1'b1;
          @(negedge clk);
          bus.rd_en = 1'b0;
        end
      end
    join
    isBreak = (d == 9'd0) && (par == PAR_NONE || p == 1'b0) && (badStop == 1);
    if (coincidentPop && q.size() != 0) void'(q.pop_front());
    if (isBreak) begin
      expBreak = 1'b1;
    end else begin
      entry = {(badStop == 1) || (badStop == 2 && stop2), flip && (par != PAR_NONE), d};
      if (q.size() < DEPTH) q.push_back(entry);
      else expOverflow = 1'b1;
    end
    modelLive = 1'b1;
  endtask

  task automatic readWord(input logic [8:0] expData, input string name);
    @(negedge clk);
    checkOutput(name, bus.rx_data, expData);
    bus.rd_en = 1'b1;
    if (q.size() != 0) void'(q.pop_front());
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulseClr();
    @(negedge clk);
    bus.clr_err = 1'b1;
    expBreak    = 1'b0;
    expOverflow = 1'b0;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    rx    = 1'b1;
    q.delete();
    expOverflow = 1'b0;
    expBreak    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    repeat (4) @(negedge clk);
    doReset();
    @(negedge clk);
    checkOutput("reset_valid", bus.rx_valid, 1'b0);
    checkOutput("reset_data", bus.rx_data, 9'h000);
    checkOutput("reset_perr", bus.rx_perr, 1'b0);
    checkOutput("reset_ferr", bus.rx_ferr, 1'b0);
    checkOutput("reset_overflow", bus.overflow, 1'b0);
    checkOutput("reset_break", bus.break_det, 1'b0);
    checkOutput("reset_idle", bus.rx_idle, 1'b1);
    modelLive = 1'b1;

    // 8N1 0xA5; also measures frame-start to RX_VALID latency.
    applyStimulus(9'h0A5, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b0);
    latency = riseCyc - frameStart;
    @(negedge clk);
    checkOutput("a5_valid", bus.rx_valid, 1'b1);
    checkOutput("a5_perr", bus.rx_perr, 1'b0);
    checkOutput("a5_ferr", bus.rx_ferr, 1'b0);
    readWord(9'h0A5, "a5_data");
    @(negedge clk);
    checkOutput("a5_empty_after_read", bus.rx_valid, 1'b0);

    // 9-bit odd parity, two stop bits.
    applyStimulus(9'h1C3, 9, PAR_ODD, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    checkOutput("o9_perr", bus.rx_perr, 1'b0);
    checkOutput("o9_ferr", bus.rx_ferr, 1'b0);
    readWord(9'h1C3, "o9_data");
    applyStimulus(9'h1C3, 9, PAR_ODD, 1'b1, 1'b1, 0, 1'b0);
    @(negedge clk);
    checkOutput("o9_flip_perr", bus.rx_perr, 1'b1);
    readWord(9'h1C3, "o9_flip_data");
    applyStimulus(9'h1C3, 9, PAR_ODD, 1'b0, 1'b1, 2, 1'b0);
    @(negedge clk);
    checkOutput("o9_stop2_ferr", bus.rx_ferr, 1'b1);
    checkOutput("o9_stop2_perr", bus.rx_perr, 1'b0);
    readWord(9'h1C3, "o9_stop2_data");

    // 7-bit mark and space parity with a zero parity bit.
    applyStimulus(9'h055, 7, PAR_MARK, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    checkOutput("mark_perr", bus.rx_perr, 1'b1);
    readWord(9'h055, "mark_data");
    applyStimulus(9'h055, 7, PAR_SPACE, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    checkOutput("space_perr", bus.rx_perr, 1'b0);
    readWord(9'h055, "space_data");

    // 5-bit even parity and an 8N1 frame with a low stop bit.
    applyStimulus(9'h01F, 5, PAR_EVEN, 1'b0, 1'b0, 0, 1'b0);
    readWord(9'h01F, "even5_data");
    applyStimulus(9'h081, 8, PAR_NONE, 1'b0, 1'b0, 1, 1'b0);
    @(negedge clk);
    checkOutput("stop1_ferr", bus.rx_ferr, 1'b1);
    readWord(9'h081, "stop1_data");

    // Short low glitch must be rejected.
    modelLive = 1'b0;
    alignToBaud();
    rx = 1'b0;
    repeat (3 * BAUD_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    modelLive = 1'b1;
    checkOutput("glitch_valid", bus.rx_valid, 1'b0);
    checkOutput("glitch_idle", bus.rx_idle, 1'b1);

    // Break: line low for 20 bit times.
    cfg_data_bits = 4'd8;
    cfg_parity    = PAR_NONE;
    cfg_stop2     = 1'b0;
    modelLive = 1'b0;
    alignToBaud();
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    expBreak  = 1'b1;
    modelLive = 1'b1;
    checkOutput("break_det", bus.break_det, 1'b1);
    checkOutput("break_no_push", bus.rx_valid, 1'b0);
    applyStimulus(9'h03C, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b0);
    readWord(9'h03C, "after_break_data");
    pulseClr();
    @(negedge clk);
    checkOutput("break_cleared", bus.break_det, 1'b0);

    // Overflow: five words into a four-entry FIFO.
    applyStimulus(9'h011, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(9'h022, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(9'h033, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(9'h044, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(9'h055, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    checkOutput("ovf_set", bus.overflow, 1'b1);
    checkOutput("ovf_head", bus.rx_data, 9'h011);
    pulseClr();
    @(negedge clk);
    checkOutput("ovf_cleared", bus.overflow, 1'b0);

    // Full FIFO with a pop in the push cycle: no overflow, oldest word leaves.
    applyStimulus(9'h066, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    checkOutput("coincident_no_ovf", bus.overflow, 1'b0);
    readWord(9'h022, "drain0");
    readWord(9'h033, "drain1");
    readWord(9'h044, "drain2");
    readWord(9'h066, "drain3");
    @(negedge clk);
    checkOutput("drain_empty", bus.rx_valid, 1'b0);

    // Reset in the middle of a frame with a word already buffered.
    applyStimulus(9'h05A, 8, PAR_NONE, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    checkOutput("pre_reset_valid", bus.rx_valid, 1'b1);
    modelLive = 1'b0;
    alignToBaud();
    rx = 1'b0;
    repeat (4 * BIT_CLKS) @(negedge clk);
    doReset();
    repeat (2 * BIT_CLKS) @(negedge clk);
    modelLive = 1'b1;
    checkOutput("midreset_valid", bus.rx_valid, 1'b0);
    checkOutput("midreset_idle", bus.rx_idle, 1'b1);
    repeat (4) @(negedge clk);

    modelLive = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_multi_mode.md
# uart_rx_multi_mode

Parametrised second-generation asynchronous UART receiver for the CoreUART APB subsystem. It oversamples a serial line on the shared baud-enable tick and majority-filters it. It deframes 5–9 data bits with a selectable parity mode and 1 or 2 stop bits, and buffers received words with per-word error status in a show-ahead receive FIFO read by the APB register block. Over the previous receiver it adds configurable oversampling, 9-bit data, mark/space parity, two-stop-bit checking, break detection, glitch-rejecting start validation and multi-entry buffering.

## Interface
- OVERSAMPLE, 16: BAUD_EN ticks per bit; even, 8..32.
- FIFO_DEPTH, 4: receive FIFO entries; power of 2, 2..64.
- CLK  in  1  system clock.
- RESET  in  1  Synchronous, active-high reset on CLK.
- BAUD_EN  in  1  one-CLK pulse per oversample tick.
- RX  in  1  asynchronous serial input; idle high.
- CFG_DATA_BITS  in  4  data bits per frame, 5..9; other values treated as 8.
- CFG_PARITY  in  3  000 none, 001 even, 010 odd, 011 mark (1), 100 space (0); others = none.
- CFG_STOP2  in  1  check two stop bits.
- RD_EN  in  1  pop FIFO head.
- CLR_ERR  in  1  clear sticky OVERFLOW and BREAK_DET.
- RX_DATA  out  9  head data, right-justified, unused upper bits 0.
- RX_PERR  out  1  head word parity error.
- RX_FERR  out  1  head word framing error.
- RX_VALID  out  1  FIFO not empty.
- OVERFLOW  out  1  sticky: word dropped because FIFO full.
- BREAK_DET  out  1  sticky: break frame received.
- RX_IDLE  out  1  deframer in IDLE.

## Operation
- Input path: 2-flop synchroniser on CLK, then a 3-bit shift register advanced on BAUD_EN. Filtered bit = majority of the 3 samples.
- All deframer counters and state advance only on cycles with BAUD_EN=1.
- FSM states:
  - IDLE: filtered low → START, tick counter = 0.
  - START: at tick OVERSAMPLE/2−1, filtered still low → latch CFG_* into frame registers, → DATA, counter = 0. If filtered high → IDLE (glitch rejected, nothing pushed).
  - DATA: sample at tick OVERSAMPLE−1, LSB first. After the latched bit count → PARITY if parity is enabled, else STOP.
  - PARITY: sample and compare. Even: XOR(data, p) = 0. Odd: = 1. Mark: p = 1. Space: p = 0.
  - STOP: sample each stop bit; any low stop sample sets the frame FERR. After the last stop bit → push, → IDLE.
  - BRK_WAIT: wait for filtered high → IDLE.
- Break: all data bits, the parity bit (if enabled) and the first stop sample are 0 → no push; set BREAK_DET; → BRK_WAIT.
- Second stop bit: if the first stop bit is good, the push occurs after the second stop sample.
- FIFO entry = {ferr, perr, data[8:0]}. A push when full and not popping in the same cycle drops the word and sets OVERFLOW.
- Simultaneous push and pop when full: both occur, no overflow.
- Pop when empty: ignored.
- CLR_ERR and a new set in the same cycle: set wins.
- CFG changes mid-frame have no effect until the next start validation.

## Timing
- Reset values: RX_DATA 0, RX_PERR 0, RX_FERR 0, RX_VALID 0, OVERFLOW 0, BREAK_DET 0, RX_IDLE 1, FIFO empty, FSM IDLE, filter register 3'b111, synchroniser 1.
- RESET mid-frame discards the frame and the FIFO contents.
- Push occurs in the BAUD_EN cycle of the final stop sample. RX_VALID and the head outputs update on the next CLK.
- Show-ahead FIFO: the head is valid whenever RX_VALID=1. RD_EN pops on its cycle, and the next head is visible the following cycle.
- BREAK_DET and OVERFLOW assert the cycle after the detecting event.
- RX_IDLE is registered and falls the cycle after the IDLE → START transition.

## Structure
- Package uart_rx_pkg holds:
  - the parity-mode encoding constants;
  - the FSM state enum {IDLE, START, DATA, PARITY, STOP, BRK_WAIT};
  - the entry width constant (11).
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO with WIDTH and DEPTH parameters, push/pop/full/empty outputs and a count, so the simultaneous push-pop-when-full case can be resolved in the parent.
- The deframer FSM, filter and sticky flags live in the top level.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 → RX_VALID=1, RX_DATA=0x0A5, RX_PERR=0, RX_FERR=0; RD_EN → RX_VALID=0.
- 9-bit, odd parity, 2 stop bits, send 0x1C3 with correct parity → RX_DATA=0x1C3. Repeat with a flipped parity bit → RX_PERR=1. Repeat with the second stop bit low → RX_FERR=1.
- 7-bit, mark parity, send 0x55 with parity 0 → RX_DATA=0x055, RX_PERR=1. Send with space parity and parity 0 → RX_PERR=0.
- Low glitch of 3 ticks on idle RX → no push, RX_IDLE returns to 1.
- Line held low for 20 bit times → BREAK_DET=1 with no push. After the line returns high, send 0x3C → received normally. CLR_ERR → BREAK_DET=0.
- FIFO_DEPTH=4: send 5 words with no reads → the first 4 are retained, OVERFLOW=1. Full FIFO with RD_EN coincident with a push → no overflow, count stays 4.
